// File: rtl/axi_multiport_bridge.sv
// N-port SRAM-like to AXI3 bridge: round-robin grant, one outstanding
// transaction per port (AXI ID = port index) and one outstanding write.
// Ports: aclk/aresetn; flattened sram_* per port (port i at [i*W +: W]);
// AXI3 AR/R/AW/W/B master channels with 4-bit IDs and 32-bit addr/data.
module axi_multiport_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_PORTS-1:0]   sram_req,
  input  logic [NUM_PORTS-1:0]   sram_wr,
  input  logic [2*NUM_PORTS-1:0] sram_size,
  input  logic [32*NUM_PORTS-1:0] sram_addr,
  input  logic [4*NUM_PORTS-1:0] sram_wstrb,
  input  logic [32*NUM_PORTS-1:0] sram_wdata,
  output logic [NUM_PORTS-1:0]   sram_addr_ok,
  output logic [NUM_PORTS-1:0]   sram_data_ok,
  output logic [32*NUM_PORTS-1:0] sram_rdata,
  output logic [3:0]             arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [3:0]             rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [3:0]             bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  logic [NUM_PORTS-1:0] busy_q, busy_d;
  logic                 wr_busy_q, wr_busy_d;
  logic [29:0]          wr_addr_q, wr_addr_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 arvalid_q, arvalid_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic [3:0]           arid_q, arid_d, awid_q, awid_d, wid_q, wid_d;
  logic [31:0]          araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [2:0]           arsize_q, arsize_d, awsize_q, awsize_d;
  logic [3:0]           wstrb_q, wstrb_d;

  logic [NUM_PORTS-1:0] elig, gnt, r_hit, b_hit;
  logic                 gnt_vld;
  int                   sel;
  logic                 unused_in;

  assign unused_in = ^{rresp, bresp, rlast};

  // Responses only count for ports that actually have one outstanding,
  // which also drops stale responses that straddle a reset.
  always_comb begin
    elig  = '0;
    r_hit = '0;
    b_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      r_hit[i] = rvalid && (rid == 4'(i)) && busy_q[i];
      b_hit[i] = bvalid && (bid == 4'(i)) && busy_q[i] && wr_busy_q;
      if (sram_req[i] && !busy_q[i]) begin
        if (sram_wr[i])
          elig[i] = !awvalid_q && !wvalid_q && !wr_busy_q;
        else
          elig[i] = !arvalid_q &&
            !(wr_busy_q && wr_addr_q == sram_addr[i*32+2 +: 30]);
      end
    end
  end

  always_comb begin
    busy_d    = busy_q & ~(r_hit | b_hit);
    wr_busy_d = wr_busy_q & ~(|b_hit);
    wr_addr_d = wr_addr_q;
    rr_ptr_d  = rr_ptr_q;
    arvalid_d = arvalid_q & ~arready;
    awvalid_d = awvalid_q & ~awready;
    wvalid_d  = wvalid_q & ~wready;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wid_d     = wid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    gnt       = '0;
    gnt_vld   = 1'b0;
    sel       = 0;
    // Search starts just after the last winner and wraps.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      sel = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!gnt_vld && aresetn && elig[sel]) begin
        gnt_vld     = 1'b1;
        gnt[sel]    = 1'b1;
        rr_ptr_d    = PW'(sel);
        busy_d[sel] = 1'b1;
        if (sram_wr[sel]) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awid_d    = 4'(sel);
          awaddr_d  = sram_addr[sel*32 +: 32];
          awsize_d  = {1'b0, sram_size[sel*2 +: 2]};
          wid_d     = 4'(sel);
          wdata_d   = sram_wdata[sel*32 +: 32];
          wstrb_d   = sram_wstrb[sel*4 +: 4];
          wr_busy_d = 1'b1;
          wr_addr_d = sram_addr[sel*32+2 +: 30];
        end else begin
          arvalid_d = 1'b1;
          arid_d    = 4'(sel);
          araddr_d  = sram_addr[sel*32 +: 32];
          arsize_d  = {1'b0, sram_size[sel*2 +: 2]};
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      busy_q    <= '0;
      wr_busy_q <= 1'b0;
      wr_addr_q <= '0;
      rr_ptr_q  <= PW'(NUM_PORTS - 1);
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wid_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      wr_busy_q <= wr_busy_d;
      wr_addr_q <= wr_addr_d;
      rr_ptr_q  <= rr_ptr_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wid_q     <= wid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign sram_addr_ok = gnt;
  assign sram_data_ok = aresetn ? (r_hit | b_hit) : '0;
  assign sram_rdata   = {NUM_PORTS{rdata}};

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = 1'b1;
  assign awid    = awid_q;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;
  assign wid     = wid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = 1'b1;

endmodule
